// File: rtl/writeback_arbiter_rr.sv
// Buffered writeback arbiter: per-channel FIFOs share one RF write port.
// Round-robin by default; define WB_FIXED_PRI_EN for fixed lowest-index priority.
module writeback_arbiter_rr #(
  parameter int REQ_CHANNELS = 4,
  parameter int FIFO_DEPTH   = 2,
  parameter int REGS_PER_RID = 64,
  parameter int VREG_W       = 6,
  parameter int DATA_W       = 32,
  parameter int RID_W        = 4,
  parameter int GREG_W       = 9
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [REQ_CHANNELS-1:0]        reqs,
  input  logic [REQ_CHANNELS*VREG_W-1:0] reqVRegIdx,
  input  logic [REQ_CHANNELS*DATA_W-1:0] reqDataVecs,
  input  logic [REQ_CHANNELS*RID_W-1:0]  reqRID,
  output logic [REQ_CHANNELS-1:0]        stallVec,
  output logic [REQ_CHANNELS-1:0]        grant_oh,
  output logic                           RFwen,
  output logic [GREG_W-1:0]              RFwAddr,
  output logic [DATA_W-1:0]              RFwData,
  output logic                           wbValid,
  output logic [RID_W-1:0]               wbRID,
  output logic [VREG_W-1:0]              wbVreg
);
  localparam int N  = REQ_CHANNELS;
  localparam int D  = FIFO_DEPTH;
  localparam int EW = VREG_W + DATA_W + RID_W;
  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam int DM = 2 ** PW;
  localparam int CW = $clog2(D + 1);
  localparam int AW = $clog2(N);

  logic [N-1:0][DM-1:0][EW-1:0] mem_q, mem_d;
  logic [N-1:0][PW-1:0]         wp_q, wp_d;
  logic [N-1:0][PW-1:0]         rp_q, rp_d;
  logic [N-1:0][CW-1:0]         cnt_q, cnt_d;
  logic [N-1:0]                 push, pop;
  logic                         found;
  logic [AW-1:0]                win;
  logic [EW-1:0]                head;

  logic              rfwen_q, rfwen_d;
  logic [N-1:0]      grant_q, grant_d;
  logic [GREG_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [RID_W-1:0]  rid_q, rid_d;
  logic [VREG_W-1:0] vreg_q, vreg_d;

`ifndef WB_FIXED_PRI_EN
  logic [AW-1:0] ptr_q, ptr_d;
`endif

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) begin
      stallVec[i] = (cnt_q[i] == CW'(D));
    end
  end

  // Reverse scan so the last hit is the first candidate in priority order.
  always_comb begin
    found = 1'b0;
    win   = '0;
`ifdef WB_FIXED_PRI_EN
    for (int i = N - 1; i >= 0; i--) begin
      if (cnt_q[i] != '0) begin
        found = 1'b1;
        win   = AW'(i);
      end
    end
`else
    for (int k = N - 1; k >= 0; k--) begin
      if (cnt_q[AW'((int'(ptr_q) + k) % N)] != '0) begin
        found = 1'b1;
        win   = AW'((int'(ptr_q) + k) % N);
      end
    end
`endif
  end

  assign head = mem_q[win][rp_q[win]];

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    push  = '0;
    pop   = '0;
    for (int i = 0; i < N; i++) begin
      push[i] = reqs[i] & ~stallVec[i];
      pop[i]  = found && (win == AW'(i));
      if (push[i]) begin
        mem_d[i][wp_q[i]] = {reqVRegIdx[i*VREG_W +: VREG_W],
                             reqDataVecs[i*DATA_W +: DATA_W],
                             reqRID[i*RID_W +: RID_W]};
        wp_d[i] = nxt(wp_q[i]);
      end
      if (pop[i]) begin
        rp_d[i] = nxt(rp_q[i]);
      end
      cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
    end
  end

  always_comb begin
    rfwen_d = found;
    grant_d = '0;
    addr_d  = addr_q;
    data_d  = data_q;
    rid_d   = rid_q;
    vreg_d  = vreg_q;
    if (found) begin
      grant_d[win] = 1'b1;
      {vreg_d, data_d, rid_d} = head;
      addr_d = GREG_W'(head[RID_W-1:0]) * GREG_W'(REGS_PER_RID)
             + GREG_W'(head[EW-1 -: VREG_W]);
    end
  end

`ifndef WB_FIXED_PRI_EN
  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (win == AW'(N - 1)) ? '0 : win + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      rfwen_q <= 1'b0;
      grant_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rid_q   <= '0;
      vreg_q  <= '0;
    end else begin
      mem_q   <= mem_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      rfwen_q <= rfwen_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rid_q   <= rid_d;
      vreg_q  <= vreg_d;
    end
  end

  assign RFwen    = rfwen_q;
  assign wbValid  = rfwen_q;
  assign grant_oh = grant_q;
  assign RFwAddr  = addr_q;
  assign RFwData  = data_q;
  assign wbRID    = rid_q;
  assign wbVreg   = vreg_q;

endmodule

// File: tb/tb_writeback_arbiter_rr.sv
// Directed bench for writeback_arbiter_rr (depth-2 main instance plus
// a depth-1 instance exercised with a sequence-numbered producer).
module tb_writeback_arbiter_rr;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  reqs;
  logic [23:0] vreg;
  logic [127:0] data;
  logic [15:0] rid;
  logic [3:0]  stall, grant;
  logic        wen, wbv;
  logic [8:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  wrid;
  logic [5:0]  wvreg;

  logic [3:0]   d1_reqs;
  logic [23:0]  d1_vreg;
  logic [127:0] d1_data;
  logic [15:0]  d1_rid;
  logic [3:0]   d1_stall, d1_grant;
  logic         d1_wen, d1_wbv;
  logic [8:0]   d1_addr;
  logic [31:0]  d1_wdata;
  logic [3:0]   d1_wrid;
  logic [5:0]   d1_wvreg;

  int checks = 0;
  int failures = 0;
  int prod [4];
  int cons [4];
  logic [3:0] pend, acc;

  writeback_arbiter_rr u_dut (
    .clk(clk), .rst(rst), .reqs(reqs), .reqVRegIdx(vreg),
    .reqDataVecs(data), .reqRID(rid), .stallVec(stall),
    .grant_oh(grant), .RFwen(wen), .RFwAddr(addr), .RFwData(wdata),
    .wbValid(wbv), .wbRID(wrid), .wbVreg(wvreg)
  );

  writeback_arbiter_rr #(.FIFO_DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .reqs(d1_reqs), .reqVRegIdx(d1_vreg),
    .reqDataVecs(d1_data), .reqRID(d1_rid), .stallVec(d1_stall),
    .grant_oh(d1_grant), .RFwen(d1_wen), .RFwAddr(d1_addr),
    .RFwData(d1_wdata), .wbValid(d1_wbv), .wbRID(d1_wrid),
    .wbVreg(d1_wvreg)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ch(input int ch, input logic [5:0] v,
                        input logic [31:0] d, input logic [3:0] r);
    vreg[ch*6 +: 6]  = v;
    data[ch*32 +: 32] = d;
    rid[ch*4 +: 4]   = r;
  endtask

  task automatic d1_check();
    if (d1_wen) begin
      chk("t5_onehot", 64'($countones(d1_grant)), 64'd1);
      for (int i = 0; i < 4; i++) begin
        if (d1_grant[i]) begin
          chk("t5_data", d1_wdata, {8'(i), 24'(cons[i])});
          cons[i]++;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    reqs = '0; vreg = '0; data = '0; rid = '0;
    d1_reqs = '0; d1_vreg = '0; d1_data = '0; d1_rid = '0;
    pend = '0; acc = '0;
    for (int i = 0; i < 4; i++) begin
      prod[i] = 0;
      cons[i] = 0;
    end
    step();
    step();
    chk("rst_wen", wen, 0);
    chk("rst_wbv", wbv, 0);
    chk("rst_grant", grant, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data", wdata, 0);
    chk("rst_rid", wrid, 0);
    chk("rst_vreg", wvreg, 0);
    chk("rst_stall", stall, 0);
    rst = 1'b0;

    // single request on ch2
    set_ch(2, 6'd5, 32'hCAFE0002, 4'd3);
    reqs = 4'b0100;
    step();
    reqs = '0;
    chk("t2_latency", wen, 0);
    step();
    chk("t2_wen", wen, 1);
    chk("t2_wbv", wbv, 1);
    chk("t2_grant", grant, 4'b0100);
    chk("t2_addr", addr, 197);
    chk("t2_rid", wrid, 3);
    chk("t2_vreg", wvreg, 5);
    chk("t2_data", wdata, 32'hCAFE0002);
    step();
    chk("t2_idle_wen", wen, 0);
    chk("t2_idle_grant", grant, 0);
    chk("t2_hold_addr", addr, 197);
    chk("t2_hold_data", wdata, 32'hCAFE0002);

    // address wrap: 15*64+63 = 1023 -> 511 in 9 bits
    set_ch(0, 6'd63, 32'h0BADF00D, 4'd15);
    reqs = 4'b0001;
    step();
    reqs = '0;
    step();
    chk("t6_wen", wen, 1);
    chk("t6_grant", grant, 4'b0001);
    chk("t6_addr", addr, 511);
    step();

    // reset while FIFOs hold data
    for (int i = 0; i < 4; i++) set_ch(i, 6'(i), 32'hDEAD0000 + i, 4'(i));
    reqs = 4'hF;
    step();
    step();
    chk("t1_busy", wen, 1);
    rst = 1'b1;
    reqs = '0;
    #1;
    chk("t1_async_wen", wen, 0);
    step();
    chk("t1_wen", wen, 0);
    chk("t1_grant", grant, 0);
    chk("t1_addr", addr, 0);
    chk("t1_data", wdata, 0);
    chk("t1_rid", wrid, 0);
    chk("t1_vreg", wvreg, 0);
    chk("t1_stall", stall, 0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("t1_no_ghost", wen, 0);
    end

    // all channels saturating from reset
    for (int i = 0; i < 4; i++) set_ch(i, 6'(i), 32'h30000000 + i, 4'(i));
    reqs = 4'hF;
    step();
    chk("t3_first", wen, 0);
    step();
    chk("t3_grant0", grant, 4'b0001);
    chk("t3_stall", stall, 4'b1110);
    chk("t3_rid0", wrid, 0);
    for (int k = 0; k < 7; k++) begin
      step();
      chk("t3_grant", grant, 4'b0001 << ((k + 1) % 4));
      chk("t3_rid", wrid, 4'((k + 1) % 4));
    end
    reqs = '0;
    for (int c = 0; c < 10; c++) step();

    // ch1 overflows its FIFO while ch0 saturates
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    set_ch(0, 6'd0, 32'h00000040, 4'd0);
    set_ch(1, 6'd1, 32'h000000A1, 4'd1);
    reqs = 4'b0011;
    step();
    set_ch(1, 6'd1, 32'h000000B2, 4'd1);
    step();
    chk("t4_grant_e1", grant, 4'b0001);
    chk("t4_stall1", stall[1], 1);
    set_ch(1, 6'd1, 32'h000000C3, 4'd1);
    step();
    chk("t4_grant_e2", grant, 4'b0010);
    chk("t4_data_a", wdata, 32'h000000A1);
    chk("t4_stall_e2", stall, 4'b0001);
    step();
    chk("t4_grant_e3", grant, 4'b0001);
    reqs = 4'b0001;
    step();
    chk("t4_grant_e4", grant, 4'b0010);
    chk("t4_data_b", wdata, 32'h000000B2);
    step();
    chk("t4_grant_e5", grant, 4'b0001);
    step();
    chk("t4_grant_e6", grant, 4'b0010);
    chk("t4_data_c", wdata, 32'h000000C3);
    reqs = '0;
    for (int c = 0; c < 6; c++) step();

    // depth-1 instance: sequence-numbered producers, per-channel order
    for (int c = 0; c < 100; c++) begin
      d1_check();
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) pend[i] = 1'b1;
        d1_reqs[i] = pend[i];
        d1_data[i*32 +: 32] = {8'(i), 24'(prod[i])};
        acc[i] = pend[i] & ~d1_stall[i];
      end
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) begin
          prod[i]++;
          pend[i] = 1'b0;
        end
      end
      @(negedge clk);
    end
    d1_reqs = '0;
    for (int c = 0; c < 8; c++) begin
      d1_check();
      step();
    end
    for (int i = 0; i < 4; i++) chk("t5_count", 64'(cons[i]), 64'(prod[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
